// File: rtl/prio_rr_arbiter_if.sv
// prio_rr_arbiter_if: request/grant bundle between requesters and the arbiter
interface prio_rr_arbiter_if #(parameter int N = 8, parameter int W = 3);
  logic [N-1:0] req;
  logic         rr_mode;
  logic         gnt_ready;
  logic         gnt_valid;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;
  modport master (output req, rr_mode, gnt_ready, input gnt_valid, gnt_idx, gnt_onehot);
  modport slave (input req, rr_mode, gnt_ready, output gnt_valid, gnt_idx, gnt_onehot);
endinterface

// File: rtl/prio_rr_arbiter.sv
// prio_rr_arbiter: fixed-priority / round-robin arbiter with registered valid/ready grant
module prio_rr_arbiter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input logic clk,
  input logic rst,
  prio_rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [W-1:0] rr_ptr, nxt_ptr, start, win, j;
  logic         found;
  logic [N-1:0] win_oh;
  assign nxt_ptr = bus.gnt_idx == '0 ? W'(N - 1) : bus.gnt_idx - W'(1);
  // on an accepting edge the new scan already starts from the post-accept pointer
  assign start  = !bus.rr_mode ? W'(N - 1) : state == GRANT ? nxt_ptr : rr_ptr;
  assign win_oh = N'(1) << win;
  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      j = W'((int'(start) + N - i) % N);
      if (!found && bus.req[j]) begin
        found = 1'b1;
        win   = j;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= W'(N - 1);
      bus.gnt_valid  <= 1'b0;
      bus.gnt_idx    <= '0;
      bus.gnt_onehot <= '0;
    end else if (state == IDLE || bus.gnt_ready) begin
      if (state == GRANT) rr_ptr <= nxt_ptr;
      state          <= found ? GRANT : IDLE;
      bus.gnt_valid  <= found;
      bus.gnt_idx    <= found ? win : '0;
      bus.gnt_onehot <= found ? win_oh : '0;
    end
endmodule

// File: doc/prio_rr_arbiter.md
PRIO_RR_ARBITER -- requirements
Module: prio_rr_arbiter

Interface
REQ-001 Parameter N, default 8: number of request lines; legal range 1..64.
REQ-002 Parameter W, default 3: index width, set to max(1, clog2(N)); the instantiator keeps W consistent with N.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  N  request vector; bit k set means requester k wants a grant.
REQ-006 rr_mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin.
REQ-007 gnt_ready  input  1  consumer accepts the presented grant when high with gnt_valid.
REQ-008 gnt_valid  output  1  a registered grant is presented.
REQ-009 gnt_idx  output  W  index of the granted requester.
REQ-010 gnt_onehot  output  N  one-hot form of gnt_idx; all zero when gnt_valid=0.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (no grant presented) and GRANT (gnt_valid=1).
REQ-012 The block SHALL hold an internal pointer rr_ptr (W bits) naming the highest-priority index for the next arbitration.
REQ-013 Arbitration SHALL pick the winner from req sampled at the arbitration edge.
- Fixed mode: scan from N-1 down to 0.
- Round-robin mode: scan from rr_ptr downward, wrapping from 0 to N-1.
- The first set bit found wins.
REQ-014 IDLE with req!=0 SHALL register the winner and enter GRANT, so gnt_valid rises one cycle after req is seen.
REQ-015 IDLE with req==0 SHALL stay in IDLE with gnt_idx=0 and gnt_onehot=0; gnt_idx is never X.
REQ-016 In GRANT with gnt_ready=0, gnt_idx and gnt_onehot SHALL remain stable, regardless of changes on req or rr_mode.
REQ-017 In GRANT, an edge with gnt_ready=1 SHALL accept the grant and apply all of the following on that same edge:
- rr_ptr is updated per REQ-018.
- If req is nonzero, a new arbitration runs using the updated rr_ptr and the block stays in GRANT, giving back-to-back grants with no bubble.
- Otherwise the block returns to IDLE and gnt_valid=0 on the next cycle.
REQ-018 On every accepted grant of index k, in either mode, rr_ptr SHALL become k-1; when k=0 it SHALL become N-1.
REQ-019 A requester dropping its req while granted SHALL NOT revoke the grant; only acceptance or reset ends a grant.
REQ-020 A change on rr_mode SHALL take effect at the next arbitration edge only.
REQ-021 With N=1 the block SHALL always grant index 0 whenever req[0]=1.
REQ-022 gnt_onehot SHALL equal (1 << gnt_idx) whenever gnt_valid=1.

Reset
REQ-023 Asserting rst SHALL, immediately and without a clock, force all of the following:
- FSM to IDLE.
- gnt_valid=0, gnt_idx=0, gnt_onehot=0.
- rr_ptr=N-1.
REQ-024 Reset asserted mid-GRANT SHALL discard the pending grant; no acceptance is recorded.
REQ-025 After rst deasserts, the first clock edge SHALL arbitrate normally if req!=0.

Verification (N=8)
REQ-026 Fixed-mode winner and latency: rr_mode=0, req=8'hA0 -> one cycle later gnt_valid=1, gnt_idx=7, gnt_onehot=8'h80.
REQ-027 Hold while not ready: gnt_idx=7 presented, gnt_ready=0, then req switches to 8'h01 -> gnt_idx stays 7 until gnt_ready=1; the next grant is then idx 0.
REQ-028 Round-robin sweep: rr_mode=1, req=8'hFF held, gnt_ready=1 continuously -> gnt_idx sequence 7,6,5,4,3,2,1,0,7, one grant per cycle with no gaps.
REQ-029 Round-robin fairness: rr_mode=1, req=8'h81, gnt_ready=1 -> gnt_idx alternates 7,0,7,0; under the same stimulus with rr_mode=0, gnt_idx stays 7 every cycle.
REQ-030 Empty request: req=8'h00 -> gnt_valid=0, gnt_idx=0, gnt_onehot=8'h00, FSM stays in IDLE.
REQ-031 Asynchronous reset mid-grant: rst pulsed between clock edges during GRANT -> outputs are zero before the next edge; with rr_mode=1, req=8'hFF the first grant after release is idx 7.
